// File: rtl/args_div.sv
// args_div: sequential unsigned divider for averaging (argument sum / count).
// One restoring-division step per cycle, MSB first, with a fixed W-cycle
// latency that does not depend on the operands, even for a zero divisor.
// Operands enter through a valid/ready handshake in IDLE. The result is held
// in DONE until the consumer takes it.
// W must be at least 2, and D must satisfy 1 <= D <= W.

module args_div #(
   parameter int W = 14,
   parameter int D = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] dividend,
   input  logic [D-1:0] divisor,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] quotient,
   output logic [D-1:0] remainder,
   output logic         div_zero
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t state;

   // The dividend register shifts out dividend bits at the top and takes in
   // quotient bits at the bottom, so it holds the full quotient after W steps.
   logic [W-1:0]  dvd_work;
   logic [D-1:0]  dvs_reg;
   logic [D-1:0]  rem_work;
   logic [CW-1:0] bit_cnt;

   logic [D:0]    shifted;
   logic          dvs_zero;
   logic          take;
   logic          q_bit;
   logic [D-1:0]  rem_next;

   // One restoring step. The partial remainder is always below the divisor,
   // so D bits are enough to store it and D+1 bits are enough to shift it.
   // A zero divisor forces a quotient bit of 1 and keeps the remainder cleared.
   always_comb begin
      shifted  = {rem_work, dvd_work[W-1]};
      dvs_zero = (dvs_reg == '0);
      take     = !dvs_zero && (shifted >= {1'b0, dvs_reg});
      q_bit    = take | dvs_zero;
      rem_next = shifted[D-1:0];
      if (dvs_zero) begin
         rem_next = '0;
      end else if (take) begin
         rem_next = D'(shifted - {1'b0, dvs_reg});
      end
   end

   // Control FSM, datapath registers and registered handshake/result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         div_zero  <= 1'b0;
         dvd_work  <= '0;
         dvs_reg   <= '0;
         rem_work  <= '0;
         bit_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  dvd_work <= dividend;
                  dvs_reg  <= divisor;
                  rem_work <= '0;
                  bit_cnt  <= CW'(W - 1);
                  in_ready <= 1'b0;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               dvd_work <= {dvd_work[W-2:0], q_bit};
               rem_work <= rem_next;
               if (bit_cnt == '0) begin
                  quotient  <= {dvd_work[W-2:0], q_bit};
                  remainder <= rem_next;
                  div_zero  <= dvs_zero;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  bit_cnt <= bit_cnt - 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_args_div.sv
// tb_args_div: self-checking bench for args_div (W=14, D=4).
// Directed corner cases plus randomized operations, checked against plain
// integer division computed in the bench.

module tb_args_div;

   localparam int W = 14;
   localparam int D = 4;
   localparam int LAT = W;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] dividend = '0;
   logic [D-1:0] divisor = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] quotient;
   logic [D-1:0] remainder;
   logic         div_zero;

   int tests = 0;
   int failures = 0;

   args_div #(.W(W), .D(D)) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .dividend(dividend),
      .divisor(divisor),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .quotient(quotient),
      .remainder(remainder),
      .div_zero(div_zero)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Single comparison point
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      tests++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   // One complete operation: offer operands, optionally inject ignored
   // operands during BUSY, then measure the latency and check the result.
   // Hold the result for hold cycles, then hand it off.
   task automatic applyStimulus(input int a, input int b, input bit noise, input int hold);
      int exp_q, exp_r, exp_z, lat, wait_cnt;
      bit seen;
      exp_q = (b == 0) ? (1 << W) - 1 : a / b;
      exp_r = (b == 0) ? 0 : a % b;
      exp_z = (b == 0) ? 1 : 0;

      wait_cnt = 0;
      @(negedge clk);
      while (!in_ready && wait_cnt < 50) begin
         @(negedge clk);
         wait_cnt++;
      end
      checkOutput("in_ready_before_op", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      dividend = W'(a);
      divisor  = D'(b);
      @(posedge clk);
      #1;
      in_valid = 1'b0;

      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (out_valid) begin
            seen = 1'b1;
            in_valid = 1'b0;
         end else if (noise) begin
            in_valid = 1'b1;
            dividend = W'($urandom);
            divisor  = D'($urandom);
         end
      end
      in_valid = 1'b0;
      checkOutput("latency", 32'(lat), 32'(LAT));
      checkOutput("quotient", 32'(quotient), 32'(exp_q));
      checkOutput("remainder", 32'(remainder), 32'(exp_r));
      checkOutput("div_zero", 32'(div_zero), 32'(exp_z));

      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
         checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
         checkOutput("hold_quotient", 32'(quotient), 32'(exp_q));
         checkOutput("hold_remainder", 32'(remainder), 32'(exp_r));
         checkOutput("hold_div_zero", 32'(div_zero), 32'(exp_z));
      end

      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput("in_ready_after_take", 32'(in_ready), 32'd1);
      checkOutput("out_valid_after_take", 32'(out_valid), 32'd0);
   endtask

   initial begin
      // Reset state
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_quotient", 32'(quotient), 32'd0);
      checkOutput("rst_remainder", 32'(remainder), 32'd0);
      checkOutput("rst_div_zero", 32'(div_zero), 32'd0);
      rst = 1'b0;

      // Directed cases
      applyStimulus(100, 9, 1'b0, 0);
      applyStimulus(16383, 1, 1'b0, 0);
      applyStimulus(16383, 15, 1'b0, 0);
      applyStimulus(5, 0, 1'b0, 0);
      applyStimulus(0, 7, 1'b0, 0);
      applyStimulus(6, 13, 1'b0, 0);
      applyStimulus(100, 9, 1'b0, 5);
      applyStimulus(1234, 7, 1'b1, 1);

      // Reset during BUSY aborts the operation
      @(negedge clk);
      in_valid = 1'b1;
      dividend = W'(777);
      divisor  = D'(5);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("abort_rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("abort_rst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("abort_rst_quotient", 32'(quotient), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("abort_idle_in_ready", 32'(in_ready), 32'd1);
      repeat (LAT + 4) @(negedge clk);
      checkOutput("abort_no_result", 32'(out_valid), 32'd0);
      applyStimulus(100, 9, 1'b0, 0);

      // Randomized operations
      for (int n = 0; n < 30; n++) begin
         applyStimulus(int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << D) - 1)),
                       1'($urandom), int'($urandom_range(0, 3)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
